// File: rtl/spi_slave_byte_port.sv
// spi_slave_byte_port
//   SPI responder, mode 0 (sample on sck rise, shift on sck fall), MSB first.
//   The whole block runs on the local clock. sck, cs and mosi are oversampled
//   through synchronizer chains, so no flop is clocked by sck. The local clock
//   must be at least 4x the sck frequency.
//
// Ports
//   clock         system clock
//   reset         synchronous, active-low reset
//   sck/cs/mosi   SPI pins from the initiator (asynchronous to clock, cs active-low)
//   miso          serial data to the initiator, 1'bz while idle
//   p_tx_data     byte to send, transferred on p_tx_valid && p_tx_ready
//   p_tx_valid    p_tx_data is valid
//   p_tx_ready    holding register is empty
//   p_rx_data     last complete received byte
//   p_rx_valid    one-clock pulse when p_rx_data holds a new byte
//   p_tx_underrun one-clock pulse when TX_IDLE was loaded for lack of data
//   p_busy        synchronized cs is low
module spi_slave_byte_port #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = 8'hFF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] p_tx_data,
  input  logic                  p_tx_valid,
  output logic                  p_tx_ready,
  output logic [DATA_WIDTH-1:0] p_rx_data,
  output logic                  p_rx_valid,
  output logic                  p_tx_underrun,
  output logic                  p_busy
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers. All three chains have the same depth so mosi stays aligned
  // with the sck edge that samples it. The extra register per signal is the
  // previous synchronized value, used only for edge detection.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;
  logic                   r_cs_prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sck_prev  <= r_sck_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
    end
  end

  logic w_sck_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_rise;
  logic w_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sck_s   = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise    =  w_sck_s & ~r_sck_prev;
  assign w_fall    = ~w_sck_s &  r_sck_prev;
  assign w_cs_fall = ~w_cs_s  &  r_cs_prev;
  assign w_cs_rise =  w_cs_s  & ~r_cs_prev;

  // ---------------------------------------------------------------------------
  // Frame state machine, holding register and shift registers
  // ---------------------------------------------------------------------------
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_hold_full;
  logic                  r_tx_ready;
  logic [DATA_WIDTH-1:0] r_shift_tx;
  logic [DATA_WIDTH-1:0] r_shift_rx;
  logic [CW-1:0]         r_cnt;
  logic                  r_byte_done;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_pend;
  logic                  r_rx_valid;
  logic                  r_underrun;
  logic                  r_busy;

  // A load happens once at the start of a frame and again on the sck fall
  // that follows a completed byte. cs_rise overrides both, which keeps an
  // unsent holding byte for the next frame.
  logic w_load;
  assign w_load = ~w_cs_rise &
                  ((r_state == ST_LOAD) |
                   ((r_state == ST_SHIFT) & w_fall & r_byte_done));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_tx_ready  <= 1'b1;
      r_shift_tx  <= '0;
      r_shift_rx  <= '0;
      r_cnt       <= '0;
      r_byte_done <= 1'b0;
      r_rx_data   <= '0;
      r_rx_pend   <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_busy     <= ~w_cs_s;
      r_rx_valid <= r_rx_pend;
      r_rx_pend  <= 1'b0;
      r_underrun <= 1'b0;

      // Local side handshake. Only possible while the holding register is
      // empty, so it can never collide with a load that drains it; a byte
      // accepted during an empty-load cycle simply waits for the next load.
      if (p_tx_valid && r_tx_ready) begin
        r_hold      <= p_tx_data;
        r_hold_full <= 1'b1;
        r_tx_ready  <= 1'b0;
      end

      if (w_load) begin
        if (r_hold_full) begin
          r_shift_tx  <= r_hold;
          r_hold_full <= 1'b0;
          r_tx_ready  <= 1'b1;
        end else begin
          r_shift_tx <= TX_IDLE;
          r_underrun <= 1'b1;
        end
      end

      if (w_cs_rise) begin
        // Partial byte is dropped; a rise in this same cycle is ignored.
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_byte_done <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt       <= '0;
            r_byte_done <= 1'b0;
            if (w_cs_fall) r_state <= ST_LOAD;
          end

          ST_LOAD: begin
            r_cnt       <= '0;
            r_byte_done <= 1'b0;
            r_state     <= ST_SHIFT;
          end

          ST_SHIFT: begin
            if (w_rise) begin
              r_shift_rx <= {r_shift_rx[DATA_WIDTH-2:0], w_mosi_s};
              if (r_cnt == CW'(DATA_WIDTH - 1)) begin
                r_rx_data   <= {r_shift_rx[DATA_WIDTH-2:0], w_mosi_s};
                r_rx_pend   <= 1'b1;
                r_cnt       <= '0;
                r_byte_done <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else if (w_fall) begin
              // With byte_done set the load logic above refills shift_tx.
              if (r_byte_done) r_byte_done <= 1'b0;
              else             r_shift_tx  <= {r_shift_tx[DATA_WIDTH-2:0], 1'b0};
            end
          end

          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign miso          = (r_state != ST_IDLE) ? r_shift_tx[DATA_WIDTH-1] : 1'bz;
  assign p_tx_ready    = r_tx_ready;
  assign p_rx_data     = r_rx_data;
  assign p_rx_valid    = r_rx_valid;
  assign p_tx_underrun = r_underrun;
  assign p_busy        = r_busy;

endmodule

// File: tb/tb_spi_slave_byte_port.sv
// Bench for spi_slave_byte_port: a behavioural mode-0 initiator drives
// sck/cs/mosi and collects miso; received bytes are scoreboarded.
module tb_spi_slave_byte_port;

  localparam int HALF = 8;  // clocks per sck half period

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sck   = 1'b0;
  logic       cs    = 1'b1;
  logic       mosi  = 1'b0;
  wire        miso;
  logic [7:0] p_tx_data  = 8'h00;
  logic       p_tx_valid = 1'b0;
  logic       p_tx_ready;
  logic [7:0] p_rx_data;
  logic       p_rx_valid;
  logic       p_tx_underrun;
  logic       p_busy;

  spi_slave_byte_port #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2),
    .TX_IDLE    (8'hFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sck          (sck),
    .cs           (cs),
    .mosi         (mosi),
    .miso         (miso),
    .p_tx_data    (p_tx_data),
    .p_tx_valid   (p_tx_valid),
    .p_tx_ready   (p_tx_ready),
    .p_rx_data    (p_rx_data),
    .p_rx_valid   (p_rx_valid),
    .p_tx_underrun(p_tx_underrun),
    .p_busy       (p_busy)
  );

  always #5 clock = ~clock;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         n_rxv  = 0;
  int         n_urun = 0;
  logic [7:0] rx_q[$];
  logic [31:0] m_out;
  logic [31:0] m_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Receive scoreboard and pulse counters
  always @(negedge clock) begin
    if (p_tx_underrun) n_urun++;
    if (p_rx_valid) begin
      n_rxv++;
      if (rx_q.size() == 0) check("rx_unexpected", {24'h0, p_rx_data}, 32'hFFFF_FFFF);
      else                  check("rx_data", {24'h0, p_rx_data}, {24'h0, rx_q.pop_front()});
    end
  end

  // Mode-0 frame of nbits from m_out (MSB first), miso collected into m_in.
  // The frame ends by releasing cs while sck is still high, so the trailing
  // sck fall lands after cs_rise and triggers no extra load.
  task automatic spi_frame(input int nbits);
    m_in = '0;
    mosi = m_out[nbits-1];
    cs   = 1'b0;
    for (int i = nbits - 1; i >= 0; i--) begin
      wclk(HALF);
      m_in = {m_in[30:0], miso};
      sck  = 1'b1;
      wclk(HALF);
      if (i == 0) begin
        cs = 1'b1;
        wclk(HALF);
        sck = 1'b0;
      end else begin
        sck  = 1'b0;
        mosi = m_out[i-1];
      end
    end
    wclk(HALF);
  endtask

  task automatic tx_put(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clock);
    while (!p_tx_ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (!p_tx_ready) check("tx_put_timeout", t, 0);
    else begin
      p_tx_data  = b;
      p_tx_valid = 1'b1;
      @(negedge clock);
      p_tx_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int u0, r0, t;

    // Reset values
    wclk(4);
    check("rst_rx_data",  p_rx_data,     0);
    check("rst_rx_valid", p_rx_valid,    0);
    check("rst_underrun", p_tx_underrun, 0);
    check("rst_busy",     p_busy,        0);
    check("rst_ready",    p_tx_ready,    1);
    reset = 1'b1;
    wclk(4);

    // 1: preloaded 5A, receive E9
    tx_put(8'h5A);
    wclk(2);
    check("t1_ready_low", p_tx_ready, 0);
    u0 = n_urun; r0 = n_rxv;
    rx_q.push_back(8'hE9);
    m_out = 32'hE9;
    spi_frame(8);
    check("t1_miso",     m_in[7:0],   8'h5A);
    check("t1_ready",    p_tx_ready,  1);
    check("t1_urun",     n_urun - u0, 0);
    check("t1_rx_count", n_rxv - r0,  1);
    check("t1_busy_end", p_busy,      0);

    // 2: no tx data, underrun once at LOAD
    u0 = n_urun; r0 = n_rxv;
    rx_q.push_back(8'h3C);
    m_out = 32'h3C;
    spi_frame(8);
    check("t2_miso",     m_in[7:0],   8'hFF);
    check("t2_urun",     n_urun - u0, 1);
    check("t2_rx_count", n_rxv - r0,  1);

    // 3: two bytes under one cs, B2 fed while the first byte shifts
    tx_put(8'hA1);
    u0 = n_urun; r0 = n_rxv;
    rx_q.push_back(8'h12);
    rx_q.push_back(8'h34);
    m_out = 32'h1234;
    fork
      spi_frame(16);
      tx_put(8'hB2);
    join
    check("t3_miso",     m_in[15:0],  16'hA1B2);
    check("t3_urun",     n_urun - u0, 0);
    check("t3_rx_count", n_rxv - r0,  2);
    check("t3_ready",    p_tx_ready,  1);

    // 4: abort after 3 rises, then a full frame
    u0 = n_urun; r0 = n_rxv;
    m_out = 32'h5;
    spi_frame(3);
    check("t4_abort_rx", n_rxv - r0,  0);
    check("t4_abort_busy", p_busy,    0);
    rx_q.push_back(8'h96);
    m_out = 32'h96;
    spi_frame(8);
    check("t4_rx_count", n_rxv - r0,  1);
    check("t4_urun",     n_urun - u0, 2);
    check("t4_miso",     m_in[7:0],   8'hFF);

    // 5: reset mid-frame after 5 bits, holding register filled meanwhile
    mosi = 1'b1;
    cs   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wclk(HALF); sck = 1'b1;
      wclk(HALF); sck = 1'b0;
    end
    tx_put(8'h77);
    check("t5_ready_low", p_tx_ready, 0);
    check("t5_busy_mid",  p_busy,     1);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("t5_rx_data",  p_rx_data,     0);
    check("t5_rx_valid", p_rx_valid,    0);
    check("t5_underrun", p_tx_underrun, 0);
    check("t5_busy",     p_busy,        0);
    check("t5_ready",    p_tx_ready,    1);
    cs  = 1'b1;
    sck = 1'b0;
    wclk(3);
    reset = 1'b1;
    wclk(8);
    r0 = n_rxv;
    rx_q.push_back(8'hA5);
    m_out = 32'hA5;
    spi_frame(8);
    check("t5_miso",     m_in[7:0],  8'hFF);
    check("t5_rx_count", n_rxv - r0, 1);

    // 6: C3 held on p_tx_valid while holding register is full
    tx_put(8'h5A);
    u0 = n_urun;
    p_tx_data  = 8'hC3;
    p_tx_valid = 1'b1;
    wclk(20);
    check("t6_ready_held", p_tx_ready, 0);
    rx_q.push_back(8'h0F);
    m_out = 32'h0F;
    fork
      spi_frame(8);
      begin
        t = 0;
        while (!p_tx_ready && t < 500) begin
          @(negedge clock);
          t++;
        end
        @(negedge clock);
        p_tx_valid = 1'b0;
        check("t6_accepted", p_tx_ready, 0);
      end
    join
    check("t6_miso_first", m_in[7:0], 8'h5A);
    rx_q.push_back(8'hF0);
    m_out = 32'hF0;
    spi_frame(8);
    check("t6_miso_second", m_in[7:0],   8'hC3);
    check("t6_urun",        n_urun - u0, 0);

    wclk(10);
    check("rx_queue_empty", rx_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_byte_port.md
Name: spi_slave_byte_port

Overview:
- System-clocked SPI responder (mode 0, MSB first) that receives bytes from an SPI initiator on mosi and returns bytes on miso.
- Oversamples sck/cs/mosi with the local clock, so no logic is clocked by sck.
- Presents a byte-wide valid/ready transmit interface and a valid-pulse receive interface to local logic.
- Sits opposite spi_module operating as master, sharing the sck/cs/mosi/miso wires.

Parameters:
- DATA_WIDTH, 8, bits per SPI frame, shift register width.
- SYNC_STAGES, 2, flip-flop stages on sck, cs and mosi (minimum 2).
- TX_IDLE, 8'hFF, byte shifted out when no transmit data is buffered.

Ports:
- clock  in  1  system clock; must be at least 4x the sck frequency.
- reset  in  1  synchronous, active-low reset.
- sck  in  1  SPI clock from the initiator; asynchronous to clock.
- cs  in  1  chip select, active-low.
- mosi  in  1  serial data from the initiator.
- miso  out  1  serial data to the initiator; 1'bz while cs is high or reset is low.
- p_tx_data  in  DATA_WIDTH  byte to send.
- p_tx_valid  in  1  p_tx_data is valid.
- p_tx_ready  out  1  holding register is empty.
- p_rx_data  out  DATA_WIDTH  last complete received byte.
- p_rx_valid  out  1  one-clock pulse when a new byte is in p_rx_data.
- p_tx_underrun  out  1  one-clock pulse when TX_IDLE is loaded because the holding register was empty.
- p_busy  out  1  high while cs is (synchronized) low.

Behaviour:
- Reset values (reset low at a clock edge):
  - p_rx_data=0, p_rx_valid=0, p_tx_underrun=0, p_busy=0, p_tx_ready=1, miso=z.
  - Holding register emptied, bit counter=0, synchronizers filled with sck=0, cs=1, mosi=0.
- Synchronization and edges:
  - sck, cs and mosi pass through identical SYNC_STAGES chains, plus one extra register used for edge detection.
  - rise/fall and cs_fall/cs_rise are single-clock strobes.
- Transmit handshake:
  - Transfer occurs when p_tx_valid && p_tx_ready at a clock edge; the holding register fills and p_tx_ready drops the next cycle.
  - p_tx_ready returns high the cycle after the holding register is moved into the shift register.
- State machine:
  - IDLE: miso=z, p_busy=0. On cs_fall go to LOAD.
  - LOAD (1 cycle): shift_tx takes the holding register if full, else TX_IDLE with a p_tx_underrun pulse. Bit counter=0. Go to SHIFT. miso=shift_tx[MSB] from this cycle.
  - SHIFT:
    - On rise: shift_rx <= {shift_rx[MSB-1:0], mosi_sync}, counter+1.
    - When counter reaches DATA_WIDTH on a rise: p_rx_data <= the completed byte, p_rx_valid pulses the next cycle, counter wraps to 0, byte_done=1.
    - On fall: if byte_done, load as in LOAD (same underrun rule) and clear byte_done; else shift shift_tx left by 1.
  - Any state, cs_rise: go to IDLE, discard the partial byte (no p_rx_valid), clear counter and byte_done, miso=z. The holding register is retained if not yet loaded.
- Latency:
  - From the sck pin rising edge (8th bit) to p_rx_valid high: SYNC_STAGES+2 clocks.
  - From cs pin falling to a valid miso: SYNC_STAGES+2 clocks.
- Simultaneous events:
  - A tx handshake in the same cycle as a load is not used for that load; that byte waits in the holding register for the next frame.
  - cs_rise in the same cycle as rise: cs_rise wins; the bit is discarded.
- rise and fall cannot coincide, given the 4x clock ratio.

Test Plan:
- Holding register preloaded with 8'h5A; initiator sends 8'b11101001 -> p_rx_data=8'hE9 with one p_rx_valid pulse; initiator captures 8'h5A on miso; p_tx_ready returns to 1 after LOAD.
- No tx data written; one frame -> miso shifts 8'hFF, p_tx_underrun pulses once at LOAD, p_rx_valid still pulses with the received byte.
- Back-to-back frames under one cs: initiator sends 8'h12 then 8'h34; local side feeds 8'hA1 then 8'hB2 -> two p_rx_valid pulses (8'h12, 8'h34); miso carries A1 then B2; no underrun.
- cs raised after 3 sck rises -> no p_rx_valid, miso=z within SYNC_STAGES+2 clocks; the next full frame receives the correct byte with the counter restarted.
- reset driven low mid-frame (after 5 bits) -> next clock shows all outputs at reset values; a frame after reset releases works normally.
- p_tx_valid held high with 8'hC3 while p_tx_ready=0 -> no overwrite; the byte is accepted only when p_tx_ready=1 and is transmitted in the following frame.
